pla_sweep_checker: RTL and testbench



---
 rtl/pla_sweep_checker.sv | 145 ++++++++++++++
 tb/tb_pla_sweep_checker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pla_sweep_checker.sv
// pla_sweep_checker: drives every minterm of an N_IN-input netlist, counts the
// on-set and compacts y_in into a MISR signature checked against a golden value.
// Optional macro TT_CAPTURE_EN adds a captured truth table with a read port.
module pla_sweep_checker #(
    parameter int unsigned N_IN   = 8,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned MISR_W = 16,
    parameter logic [MISR_W-1:0] POLY = MISR_W'(16'h100B)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   x_out,
    input  logic              y_in,
    input  logic [MISR_W-1:0] golden,
    output logic              busy,
    output logic              done,
    output logic [N_IN:0]     ones_count,
    output logic [MISR_W-1:0] signature,
    output logic              match
`ifdef TT_CAPTURE_EN
    ,
    input  logic [N_IN-1:0]   tt_addr,
    output logic              tt_bit
`endif
);

    localparam int unsigned CNT_W    = N_IN + 1;
    localparam int unsigned SET_W    = 4;
    localparam int unsigned TT_DEPTH = 2 ** N_IN;
    localparam logic [N_IN-1:0]  X_MAX       = {N_IN{1'b1}};
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'((SETTLE == 0) ? 0 : SETTLE - 1);

    typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, FINISH} state_t;

    state_t             state, state_nxt;
    logic [SET_W-1:0]   settle_cnt, settle_cnt_nxt;
    logic [N_IN-1:0]    x_nxt;
    logic               busy_nxt, done_nxt, match_nxt;
    logic [CNT_W-1:0]   ones_nxt;
    logic [MISR_W-1:0]  sig_nxt;
    logic [MISR_W-1:0]  misr_step;

    // One MISR step absorbing the current netlist output.
    always_comb begin
        misr_step = {signature[MISR_W-2:0], y_in} ^ (signature[MISR_W-1] ? POLY : '0);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            x_out      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ones_count <= '0;
            signature  <= '0;
            match      <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
            x_out      <= x_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            ones_count <= ones_nxt;
            signature  <= sig_nxt;
            match      <= match_nxt;
        end
    end

    // Next-state and next-output decode; start is only honoured in IDLE.
    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        x_nxt          = x_out;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        ones_nxt       = ones_count;
        sig_nxt        = signature;
        match_nxt      = match;
        case (state)
            IDLE: begin
                if (start) begin
                    ones_nxt       = '0;
                    sig_nxt        = '0;
                    match_nxt      = 1'b0;
                    settle_cnt_nxt = '0;
                    x_nxt          = '0;
                    busy_nxt       = 1'b1;
                    state_nxt      = (SETTLE == 0) ? SAMPLE : HOLD;
                end
            end
            HOLD: begin
                if (settle_cnt == SETTLE_LAST) begin
                    settle_cnt_nxt = '0;
                    state_nxt      = SAMPLE;
                end else begin
                    settle_cnt_nxt = settle_cnt + SET_W'(1);
                end
            end
            SAMPLE: begin
                ones_nxt = ones_count + CNT_W'(y_in);
                sig_nxt  = misr_step;
                if (x_out == X_MAX) begin
                    // Compare the final signature so match is valid with done.
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    match_nxt = (misr_step == golden);
                    state_nxt = FINISH;
                end else begin
                    x_nxt     = x_out + N_IN'(1);
                    state_nxt = (SETTLE == 0) ? SAMPLE : HOLD;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef TT_CAPTURE_EN
    logic [TT_DEPTH-1:0] tt_q;

    // Truth-table capture, one bit per sampled minterm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tt_q <= '0;
        end else if (state == IDLE && start) begin
            tt_q <= '0;
        end else if (state == SAMPLE) begin
            tt_q[x_out] <= y_in;
        end
    end

    // Combinational table read.
    always_comb begin
        tt_bit = tt_q[tt_addr];
    end
`endif

endmodule

// File: tb/tb_pla_sweep_checker.sv
// Self-checking bench for pla_sweep_checker with a queue-based scoreboard.
module tb_pla_sweep_checker;

    localparam int unsigned N_IN     = 8;
    localparam int unsigned MISR_W   = 16;
    localparam int unsigned SETTLE   = 1;
    localparam int unsigned VECS     = 256;
    localparam int unsigned BUSY_LEN = VECS * (SETTLE + 1);
    localparam logic [15:0] POLY     = 16'h100B;

    logic              clk, rst, start, y_in;
    logic [N_IN-1:0]   x_out;
    logic [MISR_W-1:0] golden;
    logic              busy, done, match;
    logic [N_IN:0]     ones_count;
    logic [MISR_W-1:0] signature;
`ifdef TT_CAPTURE_EN
    logic [N_IN-1:0]   tt_addr;
    logic              tt_bit;
`endif

    int checks = 0;
    int errors = 0;
    int mode   = 0;

    typedef struct {
        logic [N_IN:0]     ones;
        logic [MISR_W-1:0] sig;
        logic              mt;
    } exp_t;
    exp_t exp_q[$];

    pla_sweep_checker #(.N_IN(N_IN), .SETTLE(SETTLE), .MISR_W(MISR_W), .POLY(POLY)) dut (
        .clk(clk), .rst(rst), .start(start), .x_out(x_out), .y_in(y_in),
        .golden(golden), .busy(busy), .done(done), .ones_count(ones_count),
        .signature(signature), .match(match)
`ifdef TT_CAPTURE_EN
        , .tt_addr(tt_addr), .tt_bit(tt_bit)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Netlist stand-in selected by mode.
    always_comb begin
        case (mode)
            1:       y_in = x_out[0];
            2:       y_in = &x_out;
            3:       y_in = x_out[7] & x_out[1];
            default: y_in = 1'b0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic ref_y(input int m, input logic [7:0] v);
        case (m)
            1:       return v[0];
            2:       return v == 8'hFF;
            3:       return v[7] && v[1];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] ref_sig(input int m);
        logic [15:0] s = 16'h0;
        logic        fb;
        for (int v = 0; v < VECS; v++) begin
            fb = s[15];
            s  = {s[14:0], ref_y(m, 8'(v))};
            if (fb) s = s ^ POLY;
        end
        return s;
    endfunction

    function automatic logic [8:0] ref_ones(input int m);
        int n = 0;
        for (int v = 0; v < VECS; v++) n += int'(ref_y(m, 8'(v)));
        return 9'(n);
    endfunction

    task automatic run_sweep(input int m, input logic [15:0] gold, input bit inject);
        exp_t e;
        int   cycles = 0;
        int   dones  = 0;
        bit   seen   = 1'b0;
        mode   = m;
        golden = gold;
        e.ones = ref_ones(m);
        e.sig  = ref_sig(m);
        e.mt   = (e.sig == gold);
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (busy) cycles++;
            if (done) seen = 1'b1;
            start = inject && (cycles == 10 || cycles == 300);
        end
        start = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
        e = exp_q.pop_front();
        if (seen) begin
            check("busy_len", 32'(cycles), 32'(BUSY_LEN));
            check("busy_at_done", 32'(busy), 32'd0);
            check("ones_count", 32'(ones_count), 32'(e.ones));
            check("signature", 32'(signature), 32'(e.sig));
            check("match", 32'(match), 32'(e.mt));
            check("x_out_final", 32'(x_out), 32'hFF);
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (done) dones++;
            end
            check("done_single", 32'(dones), 32'd0);
            check("sig_hold", 32'(signature), 32'(e.sig));
        end
    endtask

    initial begin
        int rst_dones = 0;
        rst    = 1'b1;
        start  = 1'b0;
        golden = '0;
`ifdef TT_CAPTURE_EN
        tt_addr = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_x_out", 32'(x_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ones", 32'(ones_count), 32'd0);
        check("rst_sig", 32'(signature), 32'd0);
        check("rst_match", 32'(match), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_sweep(0, 16'h0000, 1'b0);
        run_sweep(1, ref_sig(1), 1'b0);
        run_sweep(1, ref_sig(1) ^ 16'h0001, 1'b0);
        run_sweep(2, ref_sig(2), 1'b0);
        run_sweep(1, ref_sig(1), 1'b1);

        // Asynchronous reset in the middle of a sweep.
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (199) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_x_out", 32'(x_out), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ones", 32'(ones_count), 32'd0);
        check("mid_rst_sig", 32'(signature), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) rst_dones++;
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) rst_dones++;
        end
        check("mid_rst_no_done", 32'(rst_dones), 32'd0);
        run_sweep(1, ref_sig(1), 1'b0);

`ifdef TT_CAPTURE_EN
        run_sweep(3, ref_sig(3), 1'b0);
        tt_addr = 8'h82; #1 check("tt_82", 32'(tt_bit), 32'd1);
        tt_addr = 8'hFF; #1 check("tt_FF", 32'(tt_bit), 32'd1);
        tt_addr = 8'h80; #1 check("tt_80", 32'(tt_bit), 32'd0);
        tt_addr = 8'h02; #1 check("tt_02", 32'(tt_bit), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
